// File: rtl/uart_rx_axis_bridge.sv
// UART receive byte stream to AXI4-Stream bridge.
// A one-byte staging register holds the newest byte. Its tlast flag is decided
// when the next byte arrives or when the idle timer expires. Staged bytes are
// pushed into a {last, data} FIFO that drives the AXIS master port.
module uart_rx_axis_bridge #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned PKT_LEN      = 16,
  parameter int unsigned IDLE_TIMEOUT = 20000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT);

  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(IDLE_TIMEOUT - 1);

  logic [DATA_BITS:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS:0]   head;

  logic [DATA_BITS-1:0] stg_data;
  logic                 stg_valid;
  logic [CW-1:0]        byte_cnt;
  logic [TW-1:0]        timer;

  logic case_a;
  logic case_b;
  logic case_c;
  logic push_req;
  logic push_last;
  logic pop;
  logic push_ok;
  logic drop;

  // Classify the cycle into push events and decide FIFO accept/drop.
  always_comb begin
    case_a    = rx_valid & stg_valid;
    case_b    = rx_valid & ~stg_valid;
    case_c    = ~rx_valid & stg_valid & (timer == TMR_LAST);
    push_req  = case_a | case_c;
    push_last = case_c | (byte_cnt == CNT_LAST);
    pop       = m_axis_tvalid & m_axis_tready;
    push_ok   = push_req & ((fifo_level != FULL_LVL) | pop);
    drop      = push_req & ~push_ok;
  end

  // Staging register, packet byte counter and idle timer.
  // byte_cnt advances on every push request, dropped or not, so that packet
  // framing follows the input stream rather than what the FIFO accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_data  <= '0;
      stg_valid <= 1'b0;
      byte_cnt  <= '0;
      timer     <= '0;
    end else begin
      if (case_a) begin
        stg_data <= rx_data;
        byte_cnt <= push_last ? '0 : byte_cnt + CW'(1);
        timer    <= '0;
      end else if (case_b) begin
        stg_data  <= rx_data;
        stg_valid <= 1'b1;
        timer     <= '0;
      end else if (case_c) begin
        stg_valid <= 1'b0;
        byte_cnt  <= '0;
        timer     <= '0;
      end else if (stg_valid) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
    end
  end

  // FIFO storage; contents need no reset because fifo_level gates the output.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_last, stg_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // AXIS outputs come from the head entry and are forced to zero while empty.
  always_comb begin
    head          = mem[rd_ptr];
    m_axis_tvalid = (fifo_level != '0);
    m_axis_tdata  = m_axis_tvalid ? head[DATA_BITS-1:0] : '0;
    m_axis_tlast  = m_axis_tvalid & head[DATA_BITS];
  end

endmodule

// File: tb/tb_uart_rx_axis_bridge.sv
// Directed bench for uart_rx_axis_bridge with PKT_LEN=4, FIFO_DEPTH=16,
// IDLE_TIMEOUT=150. Inputs are driven on the falling edge and outputs are
// checked on the falling edge.
module tb_uart_rx_axis_bridge;

  localparam int unsigned T = 150;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tlast;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [8:0] got [$];
  logic [8:0] exp_q [$];

  uart_rx_axis_bridge #(
    .DATA_BITS   (8),
    .FIFO_DEPTH  (16),
    .PKT_LEN     (4),
    .IDLE_TIMEOUT(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  // Record every accepted beat as {tlast, tdata}.
  always @(negedge clk) begin
    #1;
    if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    logic seen;

    // Reset state
    step(3);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    step(2);

    // Single-byte timeout flush
    m_axis_tready = 1'b1;
    send_byte(8'hA5);
    seen = 1'b0;
    for (int i = 1; i < T; i++) begin
      step(1);
      seen |= m_axis_tvalid;
    end
    chk("flush_quiet", 32'(seen), 32'd0);
    step(1);
    chk("flush_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("flush_tdata", 32'(m_axis_tdata), 32'hA5);
    chk("flush_tlast", 32'(m_axis_tlast), 32'd1);
    step(1);
    chk("flush_one_beat", 32'(m_axis_tvalid), 32'd0);

    // Packet boundary at PKT_LEN=4
    got.delete();
    for (int i = 1; i <= 6; i++) begin
      send_byte(8'(i));
      step(99);
    end
    step(T + 5);
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h005, 9'h106};
    check_stream("pkt");

    // Backpressure fill and overflow from the timeout push
    got.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      if (i != 16) step(2);
    end
    chk("fill_level", 32'(fifo_level), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd0);
    chk("fill_head", 32'(m_axis_tdata), 32'h00);
    step(T - 1);
    chk("fill_ovf_pre_timeout", 32'(overflow), 32'd0);
    step(1);
    chk("fill_ovf_drop", 32'(overflow), 32'd1);
    chk("fill_level_hold", 32'(fifo_level), 32'd16);
    chk("fill_head_hold", 32'(m_axis_tdata), 32'h00);

    // Overflow clear with no drop
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Push with simultaneous pop while full
    send_byte(8'h20);
    step(2);
    rx_data       = 8'h21;
    rx_valid      = 1'b1;
    m_axis_tready = 1'b1;
    step(1);
    rx_valid      = 1'b0;
    m_axis_tready = 1'b0;
    chk("full_pp_level", 32'(fifo_level), 32'd16);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", 32'(m_axis_tdata), 32'h01);

    // Drop coinciding with ovf_clr: set wins
    step(2);
    rx_data  = 8'h22;
    rx_valid = 1'b1;
    ovf_clr  = 1'b1;
    step(1);
    rx_valid = 1'b0;
    ovf_clr  = 1'b0;
    chk("drop_clr_ovf", 32'(overflow), 32'd1);
    chk("drop_clr_level", 32'(fifo_level), 32'd16);

    // Drain one per cycle, then flush of staged 0x22
    m_axis_tready = 1'b1;
    step(15);
    chk("drain_level_15", 32'(fifo_level), 32'd1);
    step(1);
    chk("drain_level_16", 32'(fifo_level), 32'd0);
    step(T + 5);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({(i % 4 == 3) ? 1'b1 : 1'b0, 8'(i)});
    exp_q.push_back(9'h020);
    exp_q.push_back(9'h122);
    check_stream("drain");

    // Asynchronous reset mid-packet
    got.delete();
    m_axis_tready = 1'b0;
    send_byte(8'h30);
    step(2);
    send_byte(8'h31);
    step(2);
    send_byte(8'h32);
    step(2);
    chk("prerst_level", 32'(fifo_level), 32'd2);
    chk("prerst_ovf", 32'(overflow), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("arst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    step(2);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    step(2);
    chk("postrst_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h40 + 8'(i));
      step(2);
    end
    step(T + 5);
    exp_q = '{9'h040, 9'h041, 9'h042, 9'h143, 9'h144};
    check_stream("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
